fma16_arbiter: RTL and testbench
================================

// Module: fma16_arbiter
// PURPOSE
//  Shares one combinational fma16 datapath between NREQ requesters (e.g. integer-pipe issue, vector
//  lanes, test DMA). Round-robin grant, registered operand stage, registered result stage with
//  valid/ready backpressure. Each response is tagged with the requester index.
// PARAMETERS
//  NREQ   4                  number of requesters, 2..8
//  IDW    $clog2(NREQ)       width of requester tag
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          synchronous, active-high reset
//  req_valid    in   NREQ       requester i has an operation pending
//  req_ready    out  NREQ       one-hot (or zero); bit i high = requester i accepted this cycle
//  req_x        in   NREQ*16    packed x operands, requester i at [16*i +: 16]
//  req_y        in   NREQ*16    packed y operands
//  req_z        in   NREQ*16    packed z operands
//  req_ctl      in   NREQ*6     packed {mul,add,negp,negz,roundmode[1:0]}, requester i at [6*i +: 6]
//  rsp_valid    out  1          result register holds a result
//  rsp_ready    in   1          consumer takes the result this cycle
//  rsp_id       out  IDW        requester index of the held result
//  rsp_result   out  16         fma16 result
//  rsp_flags    out  4          fma16 flags
//  sticky_flags out  4          (FMA16_STICKY_FLAGS_EN only) OR of all delivered flags
//  sticky_clr   in   1          (FMA16_STICKY_FLAGS_EN only) clear sticky_flags
// BEHAVIOUR
//  - Reset: req_ready=0, rsp_valid=0, rsp_id/rsp_result/rsp_flags=0, op stage invalid,
//    round-robin pointer=0, sticky_flags=0. Reset mid-operation drops all in-flight ops silently.
//  - Stages: A = operand reg {valid,id,x,y,z,ctl}; fma16 instance evaluates A combinationally;
//    B = result reg {valid,id,result,flags} driving rsp_*.
//  - advB = !B.valid | rsp_ready.  advA = !A.valid | advB.
//  - Grant: when advA, grant the first i with req_valid[i] searching from pointer upward, wrapping
//    modulo NREQ; req_ready[i]=1 for that i only. When !advA, req_ready=0. req_ready may depend
//    combinationally on req_valid and rsp_ready.
//  - Pointer: on a grant to i, pointer <= (i+1) mod NREQ; unchanged when nothing granted.
//  - Edge with grant: A <= {1,i,operands of i}. Edge with advA and no grant: A.valid <= 0.
//  - Edge with advB: B <= {A.valid, A.id, fma16 result, fma16 flags}. B holds while !advB.
//  - Latency: op accepted at edge N appears with rsp_valid=1 after edge N+1 (2 cycles).
//    Throughput 1 op/cycle while rsp_ready=1. rsp_* stable while rsp_valid & !rsp_ready.
//  - Responses return in grant order; no reordering, no drop, no duplicate.
//  - Single requester continuously valid with others idle gets every cycle; with all valid,
//    grants rotate 0,1,..,NREQ-1,0 (starvation-free; max wait NREQ-1 grants).
// CONFIGURATION
//  - FMA16_STICKY_FLAGS_EN defined: sticky_flags/sticky_clr ports exist;
//    next = (sticky_clr ? 0 : sticky_flags) | (rsp_valid & rsp_ready ? rsp_flags : 0),
//    i.e. a flag delivered in the clear cycle survives the clear.
//  - Undefined: ports absent, no sticky register; all other behaviour identical.
// TESTING
//  - Reset then idle: all req_valid=0 -> req_ready=0, rsp_valid=0 every cycle.
//  - NREQ=4, only req 2 valid, x=16'h3C00 y=16'h4000 z=16'h3C00 ctl={1,1,0,0,2'b01}, rsp_ready=1
//    -> req_ready=4'b0100 at edge N, after edge N+1 rsp_valid=1 rsp_id=2 rsp_result=16'h4200.
//  - All 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 one per cycle.
//  - rsp_ready held 0 for 5 cycles with all valid -> exactly 2 ops accepted, rsp_* frozen,
//    req_ready=0; on rsp_ready=1 results drain in order, no loss.
//  - Reset asserted with both stages valid -> next cycle rsp_valid=0, pointer=0, no stale rsp.
//  - STICKY_EN: x=16'h7BFF y=16'h7BFF (overflow) delivered -> sticky_flags nonzero; sticky_clr
//    pulse with no delivery -> 4'b0; clear coinciding with delivery -> that op's flags remain.

Source files
------------

// File: rtl/fma16_arbiter.sv
// fma16_arbiter: round-robin sharing of one combinational fma16 between NREQ requesters,
// operand stage + result stage with valid/ready backpressure. Optional FMA16_STICKY_FLAGS_EN.

module fma16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  localparam int unsigned W = 82;

  logic [15:0]  yEff;
  logic [4:0]   exP, eyP, ezP;
  logic [10:0]  mx, my, mz;
  logic         xNan, yNan, zNan, xInf, yInf, zInf, xZero, yZero;
  logic         sNan, anyNan, pInf, zInfU, invalid;
  logic         pSign, zSign, rSign;
  logic [21:0]  mp;
  logic [W-1:0] pMag, zMag, sMag;
  logic [6:0]   lead, lsb;
  logic [10:0]  q;
  logic         guard, sticky, inc, inexact, tiny, maxFinite;
  logic [16:0]  enc;

  always_comb begin
    yEff  = mul ? y : 16'h3C00;
    exP   = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    eyP   = (yEff[14:10] == 5'd0) ? 5'd1 : yEff[14:10];
    ezP   = (z[14:10] == 5'd0) ? 5'd1 : z[14:10];
    mx    = {x[14:10] != 5'd0, x[9:0]};
    my    = {yEff[14:10] != 5'd0, yEff[9:0]};
    mz    = {z[14:10] != 5'd0, z[9:0]};
    xNan  = (&x[14:10]) & (|x[9:0]);
    yNan  = (&yEff[14:10]) & (|yEff[9:0]);
    zNan  = (&z[14:10]) & (|z[9:0]);
    xInf  = (&x[14:10]) & ~(|x[9:0]);
    yInf  = (&yEff[14:10]) & ~(|yEff[9:0]);
    zInf  = (&z[14:10]) & ~(|z[9:0]);
    xZero = ~(|x[14:0]);
    yZero = ~(|yEff[14:0]);

    // Without an addend the product passes alone, so give the absent z the product's sign.
    pSign   = x[15] ^ yEff[15] ^ negp;
    zSign   = add ? (z[15] ^ negz) : pSign;
    anyNan  = xNan | yNan | (add & zNan);
    sNan    = (xNan & ~x[9]) | (yNan & ~yEff[9]) | (add & zNan & ~z[9]);
    pInf    = xInf | yInf;
    zInfU   = add & zInf;
    invalid = sNan | (~anyNan & ((xInf & yZero) | (yInf & xZero) |
                                 (pInf & zInfU & (pSign ^ zSign))));

    // Exact fixed-point sum, LSB weight 2^-48.
    mp   = 22'(mx) * 22'(my);
    pMag = W'(mp) << (7'(exP) + 7'(eyP) - 7'd2);
    zMag = add ? (W'(mz) << (7'(ezP) + 7'd23)) : '0;

    rSign = pSign;
    sMag  = '0;
    if (pSign == zSign) begin
      sMag  = pMag + zMag;
      rSign = pSign;
    end else if (pMag >= zMag) begin
      sMag  = pMag - zMag;
      rSign = pSign;
    end else begin
      sMag  = zMag - pMag;
      rSign = zSign;
    end

    lead = '0;
    for (int unsigned i = 0; i < W; i++)
      if (sMag[i]) lead = 7'(i);

    // Result LSB sits 10 below the leading one, floored at the subnormal LSB (2^-24).
    lsb     = (lead >= 7'd34) ? lead - 7'd10 : 7'd24;
    q       = 11'(sMag >> lsb);
    guard   = sMag[lsb - 7'd1];
    sticky  = |(sMag & ~({W{1'b1}} << (lsb - 7'd1)));
    inexact = guard | sticky;
    tiny    = lead < 7'd34;
    case (roundmode)
      2'b00:   inc = 1'b0;
      2'b01:   inc = guard & (sticky | q[0]);
      2'b10:   inc = inexact & rSign;
      default: inc = inexact & ~rSign;
    endcase
    // Exponent and mantissa fold into one sum so a rounding carry bumps the exponent.
    enc       = {lsb - 7'd24, 10'd0} + {6'd0, q} + 17'(inc);
    maxFinite = (roundmode == 2'b00) | ((roundmode == 2'b10) & ~rSign) |
                ((roundmode == 2'b11) & rSign);

    result = '0;
    flags  = '0;
    if (anyNan | invalid) begin
      result = 16'h7E00;
      flags  = {invalid, 3'b000};
    end else if (pInf) begin
      result = {pSign, 15'h7C00};
    end else if (zInfU) begin
      result = {zSign, 15'h7C00};
    end else if (sMag == '0) begin
      result = {(pSign == zSign) ? pSign : (roundmode == 2'b10), 15'h0000};
    end else if (enc >= 17'h07C00) begin
      result = {rSign, maxFinite ? 15'h7BFF : 15'h7C00};
      flags  = 4'b0101;
    end else begin
      result = {rSign, enc[14:0]};
      flags  = {2'b00, tiny & inexact, inexact};
    end
  end
endmodule

module fma16_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_x,
  input  logic [NREQ*16-1:0] req_y,
  input  logic [NREQ*16-1:0] req_z,
  input  logic [NREQ*6-1:0] req_ctl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_result,
  output logic [3:0]        rsp_flags
`ifdef FMA16_STICKY_FLAGS_EN
  ,
  output logic [3:0]        sticky_flags,
  input  logic              sticky_clr
`endif
);
  logic           aValid;
  logic [IDW-1:0] aId, ptr, ptrNext, grantIdx, cand;
  logic [15:0]    aX, aY, aZ;
  logic [5:0]     aCtl;
  logic           advA, advB, found, grant;
  logic [15:0]    fmaResult;
  logic [3:0]     fmaFlags;

  assign advB = ~rsp_valid | rsp_ready;
  assign advA = ~aValid | advB;

  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grantIdx = cand;
      end
    end
    grant     = found & advA & ~reset;
    req_ready = '0;
    if (grant) req_ready[grantIdx] = 1'b1;
    ptrNext = (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + IDW'(1);
  end

  fma16 uFma (
    .x        (aX),
    .y        (aY),
    .z        (aZ),
    .mul      (aCtl[5]),
    .add      (aCtl[4]),
    .negp     (aCtl[3]),
    .negz     (aCtl[2]),
    .roundmode(aCtl[1:0]),
    .result   (fmaResult),
    .flags    (fmaFlags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      aValid     <= 1'b0;
      aId        <= '0;
      aX         <= '0;
      aY         <= '0;
      aZ         <= '0;
      aCtl       <= '0;
      ptr        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (grant) begin
        aValid <= 1'b1;
        aId    <= grantIdx;
        aX     <= req_x[16*grantIdx +: 16];
        aY     <= req_y[16*grantIdx +: 16];
        aZ     <= req_z[16*grantIdx +: 16];
        aCtl   <= req_ctl[6*grantIdx +: 6];
        ptr    <= ptrNext;
      end else if (advA) begin
        aValid <= 1'b0;
      end
      if (advB) begin
        rsp_valid  <= aValid;
        rsp_id     <= aId;
        rsp_result <= fmaResult;
        rsp_flags  <= fmaFlags;
      end
    end
  end

`ifdef FMA16_STICKY_FLAGS_EN
  // A flag delivered in the clear cycle survives the clear.
  always_ff @(posedge clk) begin
    if (reset) sticky_flags <= '0;
    else       sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags) |
                               ((rsp_valid & rsp_ready) ? rsp_flags : 4'b0000);
  end
`endif
endmodule

// File: tb/tb_fma16_arbiter.sv
// Directed bench for fma16_arbiter (NREQ=4); sticky checks compile in with FMA16_STICKY_FLAGS_EN.
module tb_fma16_arbiter;
  localparam int NREQ = 4;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   reqValid;
  logic [NREQ-1:0]   reqReady;
  logic [NREQ*16-1:0] reqX, reqY, reqZ;
  logic [NREQ*6-1:0] reqCtl;
  logic              rspValid;
  logic              rspReady;
  logic [1:0]        rspId;
  logic [15:0]       rspResult;
  logic [3:0]        rspFlags;
`ifdef FMA16_STICKY_FLAGS_EN
  logic [3:0]        stickyFlags;
  logic              stickyClr;
`endif

  int total = 0;
  int bad   = 0;
  int accepted;

  logic [15:0] rrX   [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
  logic [5:0]  rrCtl [4] = '{6'b110001, 6'b110101, 6'b110001, 6'b111001};
  logic [15:0] rrExp [4] = '{16'h4200, 16'h4200, 16'h4700, 16'hC700};

  fma16_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (reqValid),
    .req_ready   (reqReady),
    .req_x       (reqX),
    .req_y       (reqY),
    .req_z       (reqZ),
    .req_ctl     (reqCtl),
    .rsp_valid   (rspValid),
    .rsp_ready   (rspReady),
    .rsp_id      (rspId),
    .rsp_result  (rspResult),
    .rsp_flags   (rspFlags)
`ifdef FMA16_STICKY_FLAGS_EN
    ,
    .sticky_flags(stickyFlags),
    .sticky_clr  (stickyClr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One op on a single requester into an empty pipe; response checked two cycles later.
  task automatic issue(input int unsigned idx, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] z, input logic [5:0] ctl,
                       input logic [15:0] expRes, input logic [3:0] expFlg, input logic clr);
    @(negedge clk);
    reqValid = '0;
    reqValid[idx] = 1'b1;
    reqX[16*idx +: 16] = x;
    reqY[16*idx +: 16] = y;
    reqZ[16*idx +: 16] = z;
    reqCtl[6*idx +: 6] = ctl;
    rspReady = 1'b1;
    #1 check("op_grant", reqReady, 32'(1) << idx);
    @(negedge clk);
    reqValid = '0;
    #1 check("op_lat_valid", rspValid, 0);
    @(negedge clk);
`ifdef FMA16_STICKY_FLAGS_EN
    stickyClr = clr;
`endif
    #1;
    check("op_valid", rspValid, 1);
    check("op_id", rspId, idx);
    check("op_result", rspResult, expRes);
    check("op_flags", rspFlags, expFlg);
    @(negedge clk);
`ifdef FMA16_STICKY_FLAGS_EN
    stickyClr = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b1; reqValid = '0; reqX = '0; reqY = '0; reqZ = '0; reqCtl = '0; rspReady = 1'b0;
`ifdef FMA16_STICKY_FLAGS_EN
    stickyClr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_id", rspId, 0);
    check("rst_result", rspResult, 0);
    check("rst_flags", rspFlags, 0);
`ifdef FMA16_STICKY_FLAGS_EN
    check("rst_sticky", stickyFlags, 0);
`endif
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("idle_ready", reqReady, 0);
      check("idle_valid", rspValid, 0);
      @(negedge clk);
    end

    issue(2, 16'h3C00, 16'h4000, 16'h3C00, 6'b110001, 16'h4200, 4'b0000, 1'b0);
    issue(1, 16'h7BFF, 16'h7BFF, 16'h0000, 6'b100001, 16'h7C00, 4'b0101, 1'b0);
`ifdef FMA16_STICKY_FLAGS_EN
    #1 check("sticky_ovf", stickyFlags, 4'b0101);
    @(negedge clk); stickyClr = 1'b1;
    @(negedge clk); stickyClr = 1'b0;
    #1 check("sticky_clr", stickyFlags, 4'b0000);
`endif
    issue(3, 16'h7C00, 16'h0000, 16'h0000, 6'b100001, 16'h7E00, 4'b1000, 1'b0);
`ifdef FMA16_STICKY_FLAGS_EN
    #1 check("sticky_nv", stickyFlags, 4'b1000);
`endif
    issue(0, 16'h7BFF, 16'h7BFF, 16'h0000, 6'b100000, 16'h7BFF, 4'b0101, 1'b1);
`ifdef FMA16_STICKY_FLAGS_EN
    #1 check("sticky_clr_deliver", stickyFlags, 4'b0101);
`endif
    issue(1, 16'h3C00, 16'h3C00, 16'h1000, 6'b110001, 16'h3C00, 4'b0001, 1'b0);
    issue(2, 16'h3C00, 16'h3C00, 16'h1000, 6'b110011, 16'h3C01, 4'b0001, 1'b0);
    issue(3, 16'h0401, 16'h3800, 16'h0000, 6'b100001, 16'h0200, 4'b0011, 1'b0);
    issue(0, 16'h3C00, 16'h3C00, 16'hBC00, 6'b110010, 16'h8000, 4'b0000, 1'b0);
    issue(1, 16'h3C00, 16'h3C00, 16'hBC00, 6'b110001, 16'h0000, 4'b0000, 1'b0);
    issue(2, 16'h4400, 16'h7BFF, 16'h0000, 6'b000001, 16'h4400, 4'b0000, 1'b0);

    // Round-robin stream from pointer 0, all requesters valid.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      reqX[16*i +: 16] = rrX[i];
      reqY[16*i +: 16] = 16'h4000;
      reqZ[16*i +: 16] = 16'h3C00;
      reqCtl[6*i +: 6] = rrCtl[i];
    end
    reqValid = '1;
    rspReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", reqReady, 32'(1) << (k % 4));
      if (k >= 2) begin
        check("rr_valid", rspValid, 1);
        check("rr_id", rspId, (k - 2) % 4);
        check("rr_result", rspResult, rrExp[(k - 2) % 4]);
      end else begin
        check("rr_valid", rspValid, 0);
      end
      @(negedge clk);
    end

    // Reset with both stages occupied.
    reset = 1'b1;
    #1 check("rst_mid_ready", reqReady, 0);
    @(negedge clk);
    reset = 1'b0;
    reqValid = '0;
    #1;
    check("rst_mid_valid", rspValid, 0);
    check("rst_mid_id", rspId, 0);
    check("rst_mid_result", rspResult, 0);
    @(negedge clk);
    #1 check("rst_mid_stale", rspValid, 0);

    // Backpressure: consumer stalls for 5 cycles.
    @(negedge clk);
    reqValid = '1;
    rspReady = 1'b0;
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      accepted += $countones(reqReady);
      if (k == 0) check("bp_ptr_reset", reqReady, 4'b0001);
      if (k >= 2) begin
        check("bp_stall_ready", reqReady, 0);
        check("bp_frozen_valid", rspValid, 1);
        check("bp_frozen_id", rspId, 0);
        check("bp_frozen_result", rspResult, 16'h4200);
      end
      @(negedge clk);
    end
    check("bp_accepted", accepted, 2);
    rspReady = 1'b1;
    #1;
    check("bp_resume_grant", reqReady, 4'b0100);
    check("bp_drain0", rspId, 0);
    @(negedge clk);
    #1;
    check("bp_grant3", reqReady, 4'b1000);
    check("bp_drain1", rspId, 1);
    check("bp_drain1_res", rspResult, 16'h4200);
    @(negedge clk);
    reqValid = '0;
    #1;
    check("bp_drain2", rspId, 2);
    check("bp_drain2_res", rspResult, 16'h4700);
    @(negedge clk);
    #1;
    check("bp_drain3", rspId, 3);
    check("bp_drain3_res", rspResult, 16'hC700);
    check("bp_drain3_valid", rspValid, 1);
    @(negedge clk);
    #1 check("bp_empty", rspValid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
